probit_window_accumulator: RTL

PROBIT_WINDOW_ACCUMULATOR -- requirements
Module: probit_window_accumulator

---
 rtl/probit_pkg.sv | 13 +
 rtl/probit_popcount.sv | 30 +++
 rtl/probit_window_accumulator.sv | 138 +++++++++++++
 3 files changed

// File: rtl/probit_pkg.sv
// rtl/probit_pkg.sv - shared state type and parameter defaults for the probit window accumulator
package probit_pkg;

   localparam int NSAMP_DEF = 8;
   localparam int NBITS_DEF = 21;
   localparam int NPER_DEF  = 17;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/probit_popcount.sv
// rtl/probit_popcount.sv - registered population count of one NSAMP-bit sample word
module probit_popcount import probit_pkg::*; #(
   parameter int NSAMP = NSAMP_DEF
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NSAMP-1:0]             bits_i,
   output logic [$clog2(NSAMP+1)-1:0]   count_o
);

   localparam int CW = $clog2(NSAMP + 1);

   logic [CW-1:0] count_d;

   always_comb begin
      count_d = '0;
      for (int i = 0; i < NSAMP; i++) begin
         count_d = count_d + CW'(bits_i[i]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_o <= '0;
      end else begin
         count_o <= count_d;
      end
   end

endmodule

// File: rtl/probit_window_accumulator.sv
// rtl/probit_window_accumulator.sv - windowed gt/lt sample accumulator with saturating sums
// and single-shot or gap-free continuous publishing with ack/overrun handshake.
module probit_window_accumulator import probit_pkg::*; #(
   parameter int NSAMP = NSAMP_DEF,
   parameter int NBITS = NBITS_DEF,
   parameter int NPER  = NPER_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [NSAMP-1:0] gt_i,
   input  logic [NSAMP-1:0] lt_i,
   input  logic [NPER-1:0]  period_i,
   input  logic             cont_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             ack_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [NBITS-1:0] gt_sum_o,
   output logic [NBITS-1:0] lt_sum_o,
   output logic             sat_o,
   output logic             overrun_o
);

   localparam int CW = $clog2(NSAMP + 1);
   localparam int W1 = NBITS + 1;

   state_t            state_q, state_d;
   logic [NPER-1:0]   per_q;
   logic [NPER-1:0]   cnt_q;
   logic              cont_q;
   logic [NBITS-1:0]  gt_acc_q, lt_acc_q;
   logic              win_sat_q;
   logic [CW-1:0]     gt_pop, lt_pop;
   logic [NBITS:0]    gt_sum, lt_sum;
   logic [NBITS-1:0]  gt_clamp, lt_clamp;
   logic              start_ok, win_end;

   probit_popcount #(.NSAMP(NSAMP)) u_pop_gt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .bits_i  (gt_i),
      .count_o (gt_pop)
   );

   probit_popcount #(.NSAMP(NSAMP)) u_pop_lt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .bits_i  (lt_i),
      .count_o (lt_pop)
   );

   // Carry bit of the widened add flags that the true sum passed 2^NBITS-1.
   assign gt_sum   = W1'(gt_acc_q) + W1'(gt_pop);
   assign lt_sum   = W1'(lt_acc_q) + W1'(lt_pop);
   assign gt_clamp = gt_sum[NBITS] ? '1 : gt_sum[NBITS-1:0];
   assign lt_clamp = lt_sum[NBITS] ? '1 : lt_sum[NBITS-1:0];

   assign start_ok = (state_q == ST_IDLE) && start_i && (period_i != '0);
   assign win_end  = (state_q == ST_RUN) && (cnt_q == per_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_ok) state_d = ST_RUN;
         ST_RUN:  if (stop_i || (win_end && !cont_q)) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q == ST_RUN);
   end

   // cnt_q == 0 marks the first RUN edge, where the popcount register still
   // holds the pre-window sample and must not be accumulated.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         per_q     <= '0;
         cont_q    <= 1'b0;
         cnt_q     <= '0;
         gt_acc_q  <= '0;
         lt_acc_q  <= '0;
         win_sat_q <= 1'b0;
      end else if (start_ok) begin
         per_q     <= period_i;
         cont_q    <= cont_i;
         cnt_q     <= '0;
         gt_acc_q  <= '0;
         lt_acc_q  <= '0;
         win_sat_q <= 1'b0;
      end else if (state_q == ST_RUN) begin
         if (win_end) begin
            cnt_q     <= NPER'(1);
            gt_acc_q  <= '0;
            lt_acc_q  <= '0;
            win_sat_q <= 1'b0;
         end else if (cnt_q == '0) begin
            cnt_q <= NPER'(1);
         end else begin
            cnt_q     <= cnt_q + NPER'(1);
            gt_acc_q  <= gt_clamp;
            lt_acc_q  <= lt_clamp;
            win_sat_q <= win_sat_q | gt_sum[NBITS] | lt_sum[NBITS];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gt_sum_o  <= '0;
         lt_sum_o  <= '0;
         sat_o     <= 1'b0;
         valid_o   <= 1'b0;
         overrun_o <= 1'b0;
      end else if (win_end) begin
         gt_sum_o <= gt_clamp;
         lt_sum_o <= lt_clamp;
         sat_o    <= win_sat_q | gt_sum[NBITS] | lt_sum[NBITS];
         valid_o  <= 1'b1;
         if (valid_o && !ack_i) begin
            overrun_o <= 1'b1;
         end
      end else if (ack_i && valid_o) begin
         valid_o   <= 1'b0;
         overrun_o <= 1'b0;
      end
   end

endmodule
